// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register busy scoreboard
// and a sequenced clear engine.
//   clk, resetb        clock, asynchronous active-low reset
//   rd_addr/rd_data    NUM_RD combinational read ports (packed, port p at [p*W +: W])
//   rd_busy            per-port pending-producer flag of the addressed register
//   wr_en/addr/data    writeback; retires the busy bit of wr_addr
//   issue_en/addr      marks issue_addr busy (wins over a same-cycle retire)
//   clr_req, clr_busy  start / activity of the register-by-register clear
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_sb #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic                 clr_req,
  output logic                 clr_busy
);

  localparam logic [AW-1:0] FIRST_IDX = AW'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [DW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic            wr_ok;
  logic            iss_ok;

  // Address is backed by a real, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok    = wr_en    && addr_ok(wr_addr)    && (state == IDLE);
  assign iss_ok   = issue_en && addr_ok(issue_addr) && (state == IDLE);
  assign clr_busy = (state == CLEAR);

  // Storage, scoreboard and clear sequencer.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok) begin
            mem[wr_addr]  <= wr_data;
            busy[wr_addr] <= 1'b0;
          end
          // Issued after the retire so a new producer overrides it.
          if (iss_ok) busy[issue_addr] <= 1'b1;
          if (clr_req) begin
            busy  <= '0;
            idx   <= FIRST_IDX;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (idx == LAST_IDX) state <= IDLE;
          else                 idx   <= idx + AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational read ports.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok;
    logic [DW-1:0] d;
    logic          b;

    assign a  = rd_addr[p*AW +: AW];
    assign ok = addr_ok(a);

    always_comb begin
      d = ok ? mem[a] : '0;
      b = ok ? busy[a] : 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (a == wr_addr)) begin
        d = wr_data;
        b = iss_ok && (issue_addr == a);
      end
`endif
    end

    assign rd_data[p*DW +: DW] = d;
    assign rd_busy[p]          = b;
  end

endmodule
